// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU Avalon master arbiter.
// Both enums are one-hot-free binary encodings; grant_t is a single bit.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/bus_grant_picker.sv
// Combinational winner selection between fetch and data requests.
// ARB_ROUND_ROBIN_EN selects alternating tie-breaks; otherwise data has fixed priority.
module bus_grant_picker
  import cpu_bus_pkg::*;
(
  input  logic   fetch_req_i,
  input  logic   data_req_i,
  input  grant_t last_grant_i,
  output grant_t grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_o = GNT_DATA;
    if (fetch_req_i && data_req_i) begin
      grant_o = (last_grant_i == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (fetch_req_i) begin
      grant_o = GNT_FETCH;
    end
  end
`else
  always_comb begin
    grant_o = (fetch_req_i && !data_req_i) ? GNT_FETCH : GNT_DATA;
  end

  // History is irrelevant under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;
`endif

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM master port between instruction fetch and load/store.
// Tie-break policy is set by ARB_ROUND_ROBIN_EN (see bus_grant_picker).
module avalon_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_req_i,
  input  logic [ADDR_W-1:0]   fetch_addr_i,
  output logic                fetch_ack_o,
  output logic [DATA_W-1:0]   fetch_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  output logic                data_ack_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [DATA_W-1:0]   writedata_o,
  output logic [DATA_W/8-1:0] byteenable_o,
  input  logic                waitrequest_i,
  input  logic [DATA_W-1:0]   readdata_i,
  output logic                busy_o
);

  localparam int unsigned BeW = DATA_W / 8;
  localparam logic [BeW-1:0] BeAll = {(BeW / 4){BE_ALL}};

  arb_state_t          state_q;
  grant_t              grant_q, last_grant_q, pick;
  logic [ADDR_W-1:0]   address_q;
  logic                read_q, write_q;
  logic [DATA_W-1:0]   writedata_q;
  logic [BeW-1:0]      byteenable_q;
  logic                fetch_ack_q, data_ack_q;
  logic [DATA_W-1:0]   fetch_rdata_q, data_rdata_q;

  bus_grant_picker u_picker (
    .fetch_req_i  (fetch_req_i),
    .data_req_i   (data_req_i),
    .last_grant_i (last_grant_q),
    .grant_o      (pick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      grant_q       <= GNT_FETCH;
      last_grant_q  <= GNT_DATA;
      address_q     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      writedata_q   <= '0;
      byteenable_q  <= '0;
      fetch_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      fetch_ack_q <= 1'b0;
      data_ack_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fetch_req_i || data_req_i) begin
            grant_q <= pick;
            state_q <= S_BUS;
            if (pick == GNT_FETCH) begin
              address_q    <= fetch_addr_i;
              read_q       <= 1'b1;
              write_q      <= 1'b0;
              writedata_q  <= '0;
              byteenable_q <= BeAll;
            end else begin
              address_q    <= data_addr_i;
              read_q       <= !data_we_i;
              write_q      <= data_we_i;
              writedata_q  <= data_wdata_i;
              byteenable_q <= data_be_i;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest_i) begin
            if (read_q) begin
              if (grant_q == GNT_FETCH) fetch_rdata_q <= readdata_i;
              else                      data_rdata_q  <= readdata_i;
            end
            read_q  <= 1'b0;
            write_q <= 1'b0;
            // Ack is raised on entry so it is high for the whole S_DONE cycle.
            if (grant_q == GNT_FETCH) fetch_ack_q <= 1'b1;
            else                      data_ack_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant_q <= grant_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address_o     = address_q;
  assign read_o        = read_q;
  assign write_o       = write_q;
  assign writedata_o   = writedata_q;
  assign byteenable_o  = byteenable_q;
  assign fetch_ack_o   = fetch_ack_q;
  assign fetch_rdata_o = fetch_rdata_q;
  assign data_ack_o    = data_ack_q;
  assign data_rdata_o  = data_rdata_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed self-checking bench for avalon_bus_arbiter.
// Expected tie-break order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_avalon_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ack_o;
  logic [31:0] fetch_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic [31:0] writedata_o;
  logic [3:0]  byteenable_o;
  logic        waitrequest_i;
  logic [31:0] readdata_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  avalon_bus_arbiter u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_req_i   (fetch_req_i),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_ack_o   (fetch_ack_o),
    .fetch_rdata_o (fetch_rdata_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_be_i     (data_be_i),
    .data_ack_o    (data_ack_o),
    .data_rdata_o  (data_rdata_o),
    .address_o     (address_o),
    .read_o        (read_o),
    .write_o       (write_o),
    .writedata_o   (writedata_o),
    .byteenable_o  (byteenable_o),
    .waitrequest_i (waitrequest_i),
    .readdata_i    (readdata_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] addr1, addr2, wdata2;

  initial begin
    rst_ni = 1'b0;
    fetch_req_i = 1'b0; fetch_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0; data_be_i = '0;
    waitrequest_i = 1'b0; readdata_i = '0;
    #2;
    chk("rst_read", read_o, 0);
    chk("rst_write", write_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", address_o, 0);
    chk("rst_be", byteenable_o, 0);
    chk("rst_acks", {fetch_ack_o, data_ack_o}, 0);
    chk("rst_rdata", {fetch_rdata_o, data_rdata_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fetch only, zero wait states.
    fetch_req_i = 1'b1; fetch_addr_i = 32'hBFC0_0000; readdata_i = 32'h2409_000A;
    tick();
    chk("f1_read", read_o, 1);
    chk("f1_be", byteenable_o, 4'hF);
    chk("f1_addr", address_o, 32'hBFC0_0000);
    chk("f1_busy", busy_o, 1);
    chk("f1_noack", fetch_ack_o, 0);
    tick();
    chk("f1_ack", fetch_ack_o, 1);
    chk("f1_rdata", fetch_rdata_o, 32'h2409_000A);
    chk("f1_dack", data_ack_o, 0);
    chk("f1_read_clr", read_o, 0);
    fetch_req_i = 1'b0;
    tick();
    chk("f1_ack_end", fetch_ack_o, 0);
    chk("f1_idle", busy_o, 0);

    // Data write with three wait states.
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0000_1000;
    data_wdata_i = 32'hDEAD_BEEF; data_be_i = 4'b0011; waitrequest_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w_write", write_o, 1);
      chk("w_read", read_o, 0);
      chk("w_addr", address_o, 32'h0000_1000);
      chk("w_wdata", writedata_o, 32'hDEAD_BEEF);
      chk("w_be", byteenable_o, 4'b0011);
      chk("w_acks", {fetch_ack_o, data_ack_o}, 0);
      if (i == 3) waitrequest_i = 1'b0;
    end
    tick();
    chk("w_dack", data_ack_o, 1);
    chk("w_fack", fetch_ack_o, 0);
    chk("w_write_clr", write_o, 0);
    chk("w_rdata_kept", data_rdata_o, 0);
    data_req_i = 1'b0;
    tick();
    chk("w_dack_end", data_ack_o, 0);
    chk("w_idle", busy_o, 0);

    // Simultaneous requests; last grant is data at this point.
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0000_0100;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0200;
    readdata_i = 32'h1111_1111;
    addr1  = Rr ? 32'h0000_0100 : 32'h0000_0200;
    addr2  = Rr ? 32'h0000_0200 : 32'h0000_0100;
    wdata2 = Rr ? 32'hDEAD_BEEF : 32'h0;
    tick();
    chk("t1_addr", address_o, addr1);
    chk("t1_read", read_o, 1);
    chk("t1_wdata", writedata_o, Rr ? 32'h0 : 32'hDEAD_BEEF);
    tick();
    chk("t1_fack", fetch_ack_o, Rr ? 1 : 0);
    chk("t1_dack", data_ack_o, Rr ? 0 : 1);
    chk("t1_rdata", Rr ? fetch_rdata_o : data_rdata_o, 32'h1111_1111);
    if (!Rr) data_req_i = 1'b0;
    readdata_i = 32'h2222_2222;
    tick();
    chk("t_gap_idle", busy_o, 0);
    tick();
    chk("t2_addr", address_o, addr2);
    chk("t2_read", read_o, 1);
    chk("t2_wdata", writedata_o, wdata2);
    tick();
    chk("t2_fack", fetch_ack_o, Rr ? 0 : 1);
    chk("t2_dack", data_ack_o, Rr ? 1 : 0);
    chk("t2_rdata", Rr ? data_rdata_o : fetch_rdata_o, 32'h2222_2222);
    fetch_req_i = 1'b0; data_req_i = 1'b0;
    tick();
    chk("t_idle", busy_o, 0);

    // Reset asserted while stalled on the bus.
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0000_0300; waitrequest_i = 1'b1;
    tick();
    chk("r_read", read_o, 1);
    tick();
    chk("r_read_hold", read_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("r_read_async", read_o, 0);
    chk("r_busy_async", busy_o, 0);
    chk("r_addr_async", address_o, 0);
    tick();
    chk("r_noack", fetch_ack_o, 0);
    chk("r_still_low", read_o, 0);
    waitrequest_i = 1'b0; readdata_i = 32'h3333_3333;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("r2_read", read_o, 1);
    chk("r2_addr", address_o, 32'h0000_0300);
    tick();
    chk("r2_ack", fetch_ack_o, 1);
    chk("r2_rdata", fetch_rdata_o, 32'h3333_3333);
    fetch_req_i = 1'b0;
    tick();
    chk("r2_idle", busy_o, 0);

    // Fetch held continuously: one transaction every three cycles.
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0000_0400; readdata_i = 32'h4444_4444;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("s_read", read_o, (c % 3 == 1) ? 1 : 0);
      chk("s_ack", fetch_ack_o, (c % 3 == 2) ? 1 : 0);
      chk("s_busy", busy_o, (c % 3 == 0) ? 0 : 1);
    end
    fetch_req_i = 1'b0;
    tick();
    chk("s_end_idle", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_bus_arbiter.md
# avalon_bus_arbiter

Shares the CPU's single Avalon memory-mapped master port between the instruction-fetch path and the load/store data path. It accepts one request per side, picks a winner, and drives the registered Avalon transaction while `waitrequest` is high. It then returns a one-cycle acknowledge with the captured read data to the winner. It sits between the CPU state machine (fetch and memory states) and the top-level `address/read/write/waitrequest/...` pins.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byteenable is `DATA_W/8`.
- `clk` in 1: system clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `fetch_req` in 1: fetch request level; held with `fetch_addr` until `fetch_ack`.
- `fetch_addr` in 32: fetch word address.
- `fetch_ack` out 1: one-cycle completion pulse.
- `fetch_rdata` out 32: instruction word, valid while `fetch_ack`=1.
- `data_req` in 1: data request level; fields held until `data_ack`.
- `data_we` in 1: 1=write, 0=read.
- `data_addr` in 32, `data_wdata` in 32, `data_be` in 4: data transaction fields.
- `data_ack` out 1, `data_rdata` out 32: completion pulse and load data.
- `address` out 32, `read` out 1, `write` out 1, `writedata` out 32, `byteenable` out 4: Avalon master outputs, all registered.
- `waitrequest` in 1, `readdata` in 32: Avalon slave responses.
- `busy` out 1: high in any state other than S_IDLE.

## Operation
- FSM states: S_IDLE, S_BUS, S_DONE.
- S_IDLE: if any request is high, latch the winner into `grant`, load the Avalon outputs, and go to S_BUS. Otherwise stay.
  - Fetch loads `read`=1, `byteenable`=4'hF, and `writedata`=0.
  - Data loads `read`=!`data_we`, `write`=`data_we`, and the addr/wdata/be fields.
- S_BUS: hold every Avalon output stable while `waitrequest`=1.
  - When `waitrequest`=0, capture `readdata` into the winner's rdata register (reads only) and clear `read`/`write`.
  - Then go to S_DONE.
- S_DONE: pulse the winner's ack for exactly this cycle, update `last_grant`, and go to S_IDLE. Requests are not sampled in S_DONE, so a requester has the ack cycle to drop or change its request.
- Arbitration happens only in S_IDLE. A request arriving during S_BUS/S_DONE waits.
- rdata registers hold their value until the next completed read for that port. Writes leave `data_rdata` unchanged.
- Reset values: state S_IDLE, `last_grant`=DATA, all outputs 0 (including `address`, `byteenable`, rdata registers, acks, `busy`).
- Reset asserted mid-transaction: `read`/`write` drop to 0 asynchronously, no ack is issued, and the aborted request must be re-presented after release.

## Timing
- Request high at edge N (in S_IDLE) → Avalon outputs asserted from cycle N+1.
- First `waitrequest`=0 sample at edge M → ack high during cycle M+1.
- Zero-wait latency: request to ack is 2 cycles. Throughput is 1 transaction per 3 cycles.
- A request held high through its ack is re-arbitrated in S_IDLE and issues a new transaction 3 cycles after the previous one started.
- `readdata` is sampled only on the edge where `read`=1 and `waitrequest`=0.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, the side not in `last_grant` wins. After reset, fetch wins the first tie.
- Undefined: fixed priority, data always beats fetch, and `last_grant` is unused (optimised away).
- A single request always wins in either mode.

## Structure
- Shared package `cpu_bus_pkg`:
  - `arb_state_t` enum (S_IDLE, S_BUS, S_DONE).
  - `grant_t` enum (GNT_FETCH, GNT_DATA).
  - Constant `BE_ALL`=4'hF.
- One combinational sub-module, `bus_grant_picker`: inputs are the two request levels and `last_grant`; output is the winning `grant_t`. The macro is evaluated inside it.

## Test plan
- Fetch only, `fetch_addr`=0xBFC00000, `waitrequest`=0, `readdata`=0x2409000A:
  - `read`=1 and `byteenable`=4'hF in cycle N+1.
  - `fetch_ack`=1 with `fetch_rdata`=0x2409000A in N+2.
- Data write at 0x00001000, `data_wdata`=0xDEADBEEF, `data_be`=4'b0011, `waitrequest` high 3 cycles:
  - `write`, address, data and be are stable for 4 cycles.
  - `data_ack` pulses once, the cycle after `waitrequest` falls.
  - `fetch_ack` stays 0.
- Both requests high at the same edge:
  - Macro undefined: data is served first, then fetch 3 cycles later.
  - Macro defined: fetch first, then data. A second tie goes to data.
- Reset pulled low while in S_BUS with `waitrequest`=1: `read` goes to 0 immediately and no ack is issued. After release, a new fetch completes normally in 2 cycles.
- `fetch_req` held high with zero wait states: `read` rises at cycles 1, 4 and 7, giving three `fetch_ack` pulses. `busy`=0 only in the S_IDLE cycles.
